// File: rtl/q4591_pkg.sv
`default_nettype none
// ============================================================================
// Module   : q4591_pkg
// Purpose  : Shared constants and sizing helpers for the mod-4591 MAC path.
// Revision : 1.0 - initial release
// ============================================================================
package q4591_pkg;

  localparam int NTRU_Q  = 4591;
  localparam int Q_HALF  = 2295;
  localparam int SUM_W   = 33;
  localparam int LEN_MAX = 815;

  // Width of a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : q4591_pkg
`default_nettype wire

// File: rtl/q4591_mul_stage.sv
`default_nettype none
// ============================================================================
// Module   : q4591_mul_stage
// Purpose  : Registered signed IN_W x IN_W multiplier carrying valid/last tags.
// Revision : 1.0 - initial release
// ============================================================================
module q4591_mul_stage #(
  parameter int IN_W = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  input  logic signed [IN_W-1:0]   a_i,
  input  logic signed [IN_W-1:0]   b_i,
  output logic                     valid_o,
  output logic                     last_o,
  output logic signed [2*IN_W-1:0] p_o
);

  logic                     valid_q;
  logic                     last_q;
  logic signed [2*IN_W-1:0] p_q;
  logic signed [2*IN_W-1:0] w_a_ext;
  logic signed [2*IN_W-1:0] w_b_ext;
  logic signed [2*IN_W-1:0] w_prod;

  // Equal-width operands keep the full signed product without width promotion surprises.
  assign w_a_ext = {{IN_W{a_i[IN_W-1]}}, a_i};
  assign w_b_ext = {{IN_W{b_i[IN_W-1]}}, b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      p_q     <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      last_q  <= valid_i & last_i;
      p_q     <= w_prod;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign p_o     = p_q;

endmodule : q4591_mul_stage
`default_nettype wire

// File: rtl/q4591_mac_acc33.sv
`default_nettype none
// ============================================================================
// Module   : q4591_mac_acc33
// Purpose  : Streaming signed MAC, one 33-bit sum per LEN products, valid/ready.
//            Optional input range check enabled by Q4591_MAC_RANGE_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module q4591_mac_acc33
  import q4591_pkg::*;
#(
  parameter int LEN  = 761,
  parameter int IN_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  a_in,
  input  logic signed [IN_W-1:0]  b_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] out_sum,
  output logic                    range_err
);

  localparam int              CNT_W    = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  logic                    ready_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic signed [SUM_W-1:0] out_sum_q, out_sum_d;
  logic                    out_valid_q, out_valid_d;

  logic                     w_stall;
  logic                     w_accept;
  logic                     w_last_term;
  logic                     w_s1_valid;
  logic                     w_s1_last;
  logic signed [2*IN_W-1:0] w_s1_p;
  logic signed [SUM_W-1:0]  w_p_ext;
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_adv;

  // Only a finished sum with nowhere to go blocks the pipe.
  assign w_stall     = out_valid_q & ~out_ready & w_s1_valid & w_s1_last;
  assign in_ready    = ready_q & ~w_stall;
  assign w_accept    = in_valid & in_ready;
  assign w_last_term = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept) cnt_d = w_last_term ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  q4591_mul_stage #(
    .IN_W (IN_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (~w_stall),
    .valid_i (w_accept),
    .last_i  (w_last_term),
    .a_i     (a_in),
    .b_i     (b_in),
    .valid_o (w_s1_valid),
    .last_o  (w_s1_last),
    .p_o     (w_s1_p)
  );

  assign w_p_ext = SUM_W'(w_s1_p);
  assign w_adv   = w_s1_valid & ~w_stall;
  // first_q marks that the next product opens a vector, so no clear cycle is needed.
  assign w_sum   = (first_q ? '0 : acc_q) + w_p_ext;

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (w_adv) begin
      acc_d   = w_sum;
      first_d = w_s1_last;
      if (w_s1_last) begin
        out_sum_d   = w_sum;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;

`ifdef Q4591_MAC_RANGE_CHK_EN
  logic range_err_q, range_err_d;
  logic w_oor;
  int   w_a_int;
  int   w_b_int;

  assign w_a_int = int'(a_in);
  assign w_b_int = int'(b_in);
  assign w_oor   = (w_a_int > Q_HALF) | (w_a_int < -Q_HALF) |
                   (w_b_int > Q_HALF) | (w_b_int < -Q_HALF);

  always_comb begin
    range_err_d = range_err_q | (w_accept & w_oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err_q <= 1'b0;
    else        range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule : q4591_mac_acc33
`default_nettype wire

// File: tb/tb_q4591_mac_acc33.sv
`default_nettype none
// ============================================================================
// Module   : tb_q4591_mac_acc33
// Purpose  : Directed self-checking bench for q4591_mac_acc33 (LEN=4 and LEN=761).
// Revision : 1.0 - initial release
// ============================================================================
module tb_q4591_mac_acc33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic               iv4, ir4, ov4, or4, re4;
  logic signed [13:0] a4, b4;
  logic signed [32:0] s4;

  logic               iv761, ir761, ov761, or761, re761;
  logic signed [13:0] a761, b761;
  logic signed [32:0] s761;

  q4591_mac_acc33 #(.LEN(4), .IN_W(14)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4),
    .out_valid(ov4), .out_ready(or4), .out_sum(s4), .range_err(re4)
  );

  q4591_mac_acc33 #(.LEN(761), .IN_W(14)) dut761 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv761), .in_ready(ir761), .a_in(a761), .b_in(b761),
    .out_valid(ov761), .out_ready(or761), .out_sum(s761), .range_err(re761)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic signed [63:0] q4[$];
  logic signed [63:0] exp_re;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && ov4 && or4) q4.push_back(64'(s4));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send4(input int a, input int b);
    int n = 0;
    a4 = 14'(a); b4 = 14'(b); iv4 = 1'b1;
    @(negedge clk);
    while (!ir4 && n < 40) begin @(negedge clk); n++; end
    if (!ir4) chk("send4_timeout", 64'(ir4), 64'sd1);
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic wait_ov4(input string tag);
    int n = 0;
    while (!ov4 && n < 40) begin @(negedge clk); n++; end
    chk(tag, 64'(ov4), 64'sd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int t0, n;
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
    iv761 = 1'b0; a761 = '0; b761 = '0; or761 = 1'b1;
`ifdef Q4591_MAC_RANGE_CHK_EN
    exp_re = 64'sd1;
`else
    exp_re = 64'sd0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(ir4), 64'sd0);
    chk("rst_out_valid", 64'(ov4), 64'sd0);
    chk("rst_out_sum",   64'(s4),  64'sd0);
    chk("rst_range_err", 64'(re4), 64'sd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rel_in_ready4",   64'(ir4),   64'sd1);
    chk("rel_in_ready761", 64'(ir761), 64'sd1);

    // 1: four terms 2295*2295, latency t+2
    @(posedge clk); #1;
    repeat (4) send4(2295, 2295);
    @(negedge clk);
    chk("t1_ov_t+1", 64'(ov4), 64'sd0);
    @(negedge clk);
    chk("t1_ov_t+2", 64'(ov4), 64'sd1);
    chk("t1_sum",    64'(s4),  64'sd21068100);
    @(negedge clk);
    chk("t1_ov_clr", 64'(ov4), 64'sd0);

    // 3: output backpressure stalls at vector-2 last product
    or4 = 1'b0;
    @(posedge clk); #1;
    repeat (4) send4(1, 1);
    repeat (4) send4(1, 2);
    @(negedge clk);
    chk("t3_stall_ready", 64'(ir4), 64'sd0);
    chk("t3_hold_valid",  64'(ov4), 64'sd1);
    chk("t3_hold_sum1",   64'(s4),  64'sd4);
    @(negedge clk);
    chk("t3_stall_ready2", 64'(ir4), 64'sd0);
    chk("t3_hold_sum1b",   64'(s4),  64'sd4);
    or4 = 1'b1;
    @(negedge clk);
    chk("t3_swap_valid", 64'(ov4), 64'sd1);
    chk("t3_sum2",       64'(s4),  64'sd8);
    @(negedge clk);
    chk("t3_drained", 64'(ov4), 64'sd0);
    @(posedge clk); #1;
    repeat (4) send4(1, 3);
    wait_ov4("t3_v3_valid");
    chk("t3_sum3", 64'(s4), 64'sd12);
    @(negedge clk);

    // 4: asynchronous reset mid-vector
    or4 = 1'b0;
    @(posedge clk); #1;
    repeat (4) send4(1, 1);
    wait_ov4("t4_pending");
    @(posedge clk); #1;
    send4(5, 5);
    send4(5, 5);
    rst_n = 1'b0;
    #1;
    chk("t4_async_ov",  64'(ov4), 64'sd0);
    chk("t4_async_rdy", 64'(ir4), 64'sd0);
    chk("t4_async_sum", 64'(s4),  64'sd0);
    @(posedge clk); #1 rst_n = 1'b1;
    or4 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) send4(1, k);
    wait_ov4("t4_valid");
    chk("t4_sum", 64'(s4), 64'sd10);
    @(negedge clk);

    // 5: continuous stream, one term per cycle
    q4.delete();
    @(posedge clk); #1;
    t0 = cyc;
    for (int v = 0; v < 3; v++)
      for (int k = 1; k <= 4; k++) send4(1, k);
    chk("t5_cycles", 64'(cyc - t0), 64'sd12);
    repeat (4) @(negedge clk);
    chk("t5_count", 64'(q4.size()), 64'sd3);
    for (int i = 0; i < 3; i++) chk("t5_sum", (i < q4.size()) ? q4[i] : 64'sd0, 64'sd10);
    chk("t5_range_err", 64'(re4), 64'sd0);

    // 2: LEN=761, 2295 * -2295 on every term
    @(posedge clk); #1;
    a761 = 14'sd2295; b761 = -14'sd2295; iv761 = 1'b1;
    for (int i = 0; i < 761; i++) begin
      n = 0;
      @(negedge clk);
      while (!ir761 && n < 40) begin @(negedge clk); n++; end
      if (!ir761) chk("t2_timeout", 64'(ir761), 64'sd1);
      @(posedge clk); #1;
    end
    iv761 = 1'b0;
    n = 0;
    while (!ov761 && n < 40) begin @(negedge clk); n++; end
    chk("t2_valid",     64'(ov761), 64'sd1);
    chk("t2_sum",       64'(s761),  -64'sd4008206025);
    chk("t2_range_err", 64'(re761), 64'sd0);

    // 6: out-of-range operand flag
    @(posedge clk); #1;
    send4(2296, 1);
    repeat (3) send4(1, 1);
    wait_ov4("t6_valid");
    chk("t6_sum",       64'(s4),  64'sd2299);
    chk("t6_range_err", 64'(re4), exp_re);
    @(negedge clk);
    @(posedge clk); #1;
    repeat (4) send4(1, 1);
    wait_ov4("t6_valid2");
    chk("t6_sum2",       64'(s4),  64'sd4);
    chk("t6_range_keep", 64'(re4), exp_re);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_q4591_mac_acc33
`default_nettype wire
